// File: rtl/spi_router_pkg.sv
// rtl/spi_router_pkg.sv - shared types, constants and helpers for the SPI chip-select router
//
// Contents:
//   state_t     : IDLE / ACTIVE / GUARD frame state
//   CNT_W       : width of the frame and bit counters
//   lowest_set  : index of the lowest set bit of a 16-bit vector (0 when none)
package spi_router_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      GUARD  = 2'd2
   } state_t;

   localparam int CNT_W = 16;

   // Scans downward so the last hit, i.e. the lowest index, wins.
   function automatic int lowest_set(input logic [15:0] v);
      int r;
      r = 0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/spi_sync2.sv
// rtl/spi_sync2.sv - parametrised-width two-flop synchroniser, resets to all ones
//
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset (flops go to 1)
//   d   : asynchronous input bus, W bits
//   q   : synchronised output bus, W bits
module spi_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // Reset value 1 keeps active-low selects deasserted and an idle-high line quiet.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/spi_cs_router.sv
// rtl/spi_cs_router.sv - SPI chip-select router, frame arbiter and MISO multiplexer
//
// Routes one host SPI port to NCH slaves. The lowest selected channel is granted
// and locked for a whole frame; SCLK/MOSI reach only the granted slave and its MISO
// is returned with a drive enable. A guard gap follows every frame.
// Optional feature macro: SPI_CS_ROUTER_BITCNT_EN (SCLK bit counting, last_bits, len_err).
//
// Ports:
//   clk, rst            : system clock, synchronous active-high reset
//   spi_sclk, spi_mosi  : host clock and data in
//   spi_cs_n [NCH]      : host per-channel selects, active-low, asynchronous
//   spi_miso_o/oe       : MISO toward IOBUF and its drive enable
//   ch_sclk/ch_mosi     : gated per-channel clock and data
//   ch_cs_n [NCH]       : registered per-channel select, active-low
//   ch_miso [NCH]       : per-channel slave MISO
//   busy, grant         : frame in progress / guard, granted channel index
//   collision, len_err  : sticky flags, cleared by clr_flags
//   frames, last_bits   : completed frame count, bit count of the last frame
module spi_cs_router
   import spi_router_pkg::*;
#(
   parameter int NCH          = 4,
   parameter int GUARD_CYCLES = 4,
   parameter int CPOL         = 0,
   localparam int GW          = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             spi_sclk,
   input  logic             spi_mosi,
   input  logic [NCH-1:0]   spi_cs_n,
   output logic             spi_miso_o,
   output logic             spi_miso_oe,
   output logic [NCH-1:0]   ch_sclk,
   output logic [NCH-1:0]   ch_mosi,
   output logic [NCH-1:0]   ch_cs_n,
   input  logic [NCH-1:0]   ch_miso,
   output logic             busy,
   output logic [GW-1:0]    grant,
   output logic             collision,
   output logic             len_err,
   output logic [CNT_W-1:0] frames,
   output logic [CNT_W-1:0] last_bits,
   input  logic             clr_flags
);

   state_t           state;
   logic [NCH-1:0]   cs_s;
   logic [NCH-1:0]   low_vec;
   logic [NCH-1:0]   grant_mask;
   logic [GW-1:0]    first_low;
   logic             multi_low;
   logic             end_frame;
   logic             coll_set;
   logic [7:0]       guard_cnt;
   logic [CNT_W-1:0] frames_q;

   spi_sync2 #(.W(NCH)) u_cs_sync (
      .clk (clk),
      .rst (rst),
      .d   (spi_cs_n),
      .q   (cs_s)
   );

   assign low_vec    = ~cs_s;
   assign grant_mask = NCH'(1) << grant;
   assign first_low  = GW'(lowest_set(16'(low_vec)));
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_low  = (low_vec & (low_vec - NCH'(1))) != '0;
   assign end_frame  = (state == ACTIVE) && cs_s[grant];

   // A select that rises on the same cycle another falls is a clean handover,
   // so the in-frame check only applies while the granted select is still low.
   always_comb begin
      coll_set = 1'b0;
      if (state == IDLE && multi_low) coll_set = 1'b1;
      if (state == ACTIVE && !cs_s[grant] && ((low_vec & ~grant_mask) != '0)) coll_set = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= '0;
         guard_cnt <= '0;
         ch_cs_n   <= '1;
         frames_q  <= '0;
         collision <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (low_vec != '0) begin
                  state   <= ACTIVE;
                  grant   <= first_low;
                  ch_cs_n <= ~(NCH'(1) << first_low);
               end
            end
            ACTIVE: begin
               if (end_frame) begin
                  state     <= GUARD;
                  guard_cnt <= 8'(GUARD_CYCLES - 1);
                  ch_cs_n   <= '1;
                  frames_q  <= frames_q + 16'd1;
               end
            end
            GUARD: begin
               if (guard_cnt == 8'd0) state <= IDLE;
               else                   guard_cnt <= guard_cnt - 8'd1;
            end
            default: begin
               state   <= IDLE;
               ch_cs_n <= '1;
            end
         endcase

         if (coll_set)       collision <= 1'b1;
         else if (clr_flags) collision <= 1'b0;
      end
   end

   assign frames = frames_q;
   assign busy   = (state != IDLE);

   always_comb begin
      ch_sclk = {NCH{1'(CPOL)}};
      ch_mosi = '0;
      for (int i = 0; i < NCH; i++) begin
         if (state == ACTIVE && grant == GW'(i)) begin
            ch_sclk[i] = spi_sclk;
            ch_mosi[i] = spi_mosi;
         end
      end
   end

   assign spi_miso_o  = (state == ACTIVE) ? ch_miso[grant] : 1'b0;
   assign spi_miso_oe = (state == ACTIVE);

`ifdef SPI_CS_ROUTER_BITCNT_EN
   logic             sclk_s;
   logic             sclk_prev;
   logic             sample_edge;
   logic [CNT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] last_bits_q;
   logic             len_err_q;

   spi_sync2 #(.W(1)) u_sclk_sync (
      .clk (clk),
      .rst (rst),
      .d   (spi_sclk),
      .q   (sclk_s)
   );

   // Sampling edge is the first edge away from the idle level.
   assign sample_edge = (CPOL != 0) ? (~sclk_s & sclk_prev) : (sclk_s & ~sclk_prev);

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_prev   <= 1'b1;
         bit_cnt     <= '0;
         last_bits_q <= '0;
         len_err_q   <= 1'b0;
      end else begin
         sclk_prev <= sclk_s;
         if (end_frame) begin
            last_bits_q <= bit_cnt;
            bit_cnt     <= '0;
         end else if (state != ACTIVE) begin
            bit_cnt <= '0;
         end else if (sample_edge && bit_cnt != 16'hFFFF) begin
            bit_cnt <= bit_cnt + 16'd1;
         end

         if (end_frame && bit_cnt[2:0] != 3'd0) len_err_q <= 1'b1;
         else if (clr_flags)                    len_err_q <= 1'b0;
      end
   end

   assign last_bits = last_bits_q;
   assign len_err   = len_err_q;
`else
   assign last_bits = '0;
   assign len_err   = 1'b0;
`endif

endmodule
